// File: rtl/io_dev_pkg.sv
// rtl/io_dev_pkg.sv - device indices, FSM states and constants for the I/O response mux
package io_dev_pkg;

    typedef enum logic [3:0] {
        LEDS,
        SDRAM_CFG,
        UART,
        SPI,
        IRQ_CTL,
        PIC,
        TIMER,
        BIOS_CTL,
        VGA_REG,
        PS2_KBD,
        PS2_MOUSE,
        PPI,
        SPARE
    } io_dev_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DONE
    } state_t;

    localparam logic [15:0] IO_FLOAT_DATA = 16'hFFFF;
    localparam int          IO_NUM_DEV    = 13;

endpackage

// File: rtl/io_onehot_prio_enc.sv
// rtl/io_onehot_prio_enc.sv - lowest-set-bit encoder with valid and multi-hot flags
module io_onehot_prio_enc #(
    parameter int N  = 13,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          valid,
    output logic          multi_hot
);

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx = IW'(i);
            end
        end
        valid     = |sel;
        multi_hot = |(sel & (sel - N'(1)));
    end

endmodule

// File: rtl/io_response_mux.sv
// rtl/io_response_mux.sv - gates the CPU I/O strobe to one decoded device and returns its ack/data
module io_response_mux
    import io_dev_pkg::*;
#(
    parameter int NUM_DEV        = IO_NUM_DEV,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_m_access,
    input  logic                  data_m_wr_en,
    input  logic                  default_io_access,
    input  logic [NUM_DEV-1:0]    dev_sel,
    input  logic [NUM_DEV-1:0]    dev_ack,
    input  logic [16*NUM_DEV-1:0] dev_data,
    output logic [NUM_DEV-1:0]    dev_access,
    output logic                  data_m_ack,
    output logic [15:0]           data_m_data_in,
    output logic                  io_timeout,
    output logic                  decode_error
);

    localparam int IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic          timeout_q, timeout_d;
    logic          dec_err_q, dec_err_d;

    logic [IW-1:0] enc_idx;
    logic          enc_valid;
    logic          enc_multi;
    logic          sel_ack;
    logic [15:0]   sel_word;

    io_onehot_prio_enc #(
        .N  (NUM_DEV),
        .IW (IW)
    ) u_prio_enc (
        .sel       (dev_sel),
        .idx       (enc_idx),
        .valid     (enc_valid),
        .multi_hot (enc_multi)
    );

    always_comb begin
        sel_ack  = 1'b0;
        sel_word = 16'h0000;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (IW'(i) == idx_q) begin
                sel_ack  = dev_ack[i];
                sel_word = dev_data[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        wr_d      = wr_q;
        timeout_d = 1'b0;
        dec_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_m_access) begin
                    // An empty select is answered like an unmapped port.
                    if (default_io_access || !enc_valid) begin
                        state_d = ACK;
                        data_d  = IO_FLOAT_DATA;
                    end else begin
                        state_d   = WAIT;
                        idx_d     = enc_idx;
                        wr_d      = data_m_wr_en;
                        cnt_d     = '0;
                        dec_err_d = enc_multi;
                    end
                end
            end
            WAIT: begin
                if (!data_m_access) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    state_d = ACK;
                    data_d  = wr_q ? 16'h0000 : sel_word;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ACK;
                    data_d    = IO_FLOAT_DATA;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ACK: begin
                state_d = DONE;
            end
            DONE: begin
                if (!data_m_access) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            data_q    <= 16'h0000;
            wr_q      <= 1'b0;
            timeout_q <= 1'b0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            timeout_q <= timeout_d;
            dec_err_q <= dec_err_d;
        end
    end

    assign dev_access     = (state_q == WAIT && data_m_access) ? (NUM_DEV'(1) << idx_q) : '0;
    assign data_m_ack     = (state_q == ACK);
    assign data_m_data_in = data_q;
    assign io_timeout     = timeout_q;
    assign decode_error   = dec_err_q;

endmodule

// File: tb/tb_io_response_mux.sv
// tb/tb_io_response_mux.sv - randomized self-checking bench for io_response_mux
module tb_io_response_mux;
    import io_dev_pkg::*;

    localparam int N = 13;
    localparam int T = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            data_m_access;
    logic            data_m_wr_en;
    logic            default_io_access;
    logic [N-1:0]    dev_sel;
    logic [N-1:0]    dev_ack;
    logic [16*N-1:0] dev_data;
    logic [N-1:0]    dev_access;
    logic            data_m_ack;
    logic [15:0]     data_m_data_in;
    logic            io_timeout;
    logic            decode_error;

    int n_checks = 0;
    int n_pass   = 0;

    io_response_mux #(
        .NUM_DEV        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .data_m_access     (data_m_access),
        .data_m_wr_en      (data_m_wr_en),
        .default_io_access (default_io_access),
        .dev_sel           (dev_sel),
        .dev_ack           (dev_ack),
        .dev_data          (dev_data),
        .dev_access        (dev_access),
        .data_m_ack        (data_m_ack),
        .data_m_data_in    (data_m_data_in),
        .io_timeout        (io_timeout),
        .decode_error      (decode_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] e_acc, input bit e_ack,
                              input bit e_to, input bit e_de, input bit chk_data,
                              input logic [15:0] e_data);
        check({tag, ".dev_access"}, 32'(dev_access), 32'(e_acc));
        check({tag, ".ack"}, 32'(data_m_ack), 32'(e_ack));
        check({tag, ".timeout"}, 32'(io_timeout), 32'(e_to));
        check({tag, ".decode_error"}, 32'(decode_error), 32'(e_de));
        if (chk_data) check({tag, ".data"}, 32'(data_m_data_in), 32'(e_data));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) dev_data[i*16 +: 16] = 16'($urandom);
    endtask

    // One CPU I/O cycle. d: WAIT cycle (1-based) in which the selected device acks, 0 = never.
    task automatic run_txn(input string tag, input logic [N-1:0] sel, input bit dflt, input bit wr,
                           input int d, input int abort_at, input int reset_at, input int hold,
                           input bit use_f, input logic [15:0] fdata);
        bit           mapped;
        bit           multi;
        bit           timed;
        int           idx;
        int           wait_len;
        logic [N-1:0] onehot;
        logic [15:0]  exp_data;

        mapped = !dflt && (sel != '0);
        multi  = ($countones(sel) > 1);
        idx    = 0;
        for (int i = N - 1; i >= 0; i--) if (sel[i]) idx = i;
        onehot   = '0;
        onehot[idx] = 1'b1;
        timed    = !(d >= 1 && d <= T);
        wait_len = timed ? T : d;
        exp_data = 16'hFFFF;

        next_cycle();
        data_m_access     = 1'b1;
        data_m_wr_en      = wr;
        default_io_access = dflt;
        dev_sel           = sel;
        dev_ack           = N'($urandom);
        rand_data();
        #2 check_outs({tag, ".idle"}, '0, 0, 0, 0, 0, 16'h0);

        if (mapped) begin
            for (int k = 1; k <= wait_len; k++) begin
                next_cycle();
                dev_sel = N'($urandom);
                rand_data();
                dev_ack = (k == 1) ? ~onehot : (N'($urandom) & ~onehot);
                if (k == d) begin
                    dev_ack[idx] = 1'b1;
                    if (use_f) dev_data[idx*16 +: 16] = fdata;
                    exp_data = wr ? 16'h0000 : dev_data[idx*16 +: 16];
                end
                if (k == abort_at) data_m_access = 1'b0;
                if (k == reset_at) reset = 1'b1;
                #2 check_outs($sformatf("%s.wait%0d", tag, k), (k == abort_at) ? '0 : onehot,
                              0, 0, (k == 1) && multi, 0, 16'h0);
                if (k == abort_at) begin
                    next_cycle();
                    dev_ack = '0;
                    #2 check_outs({tag, ".abort"}, '0, 0, 0, 0, 0, 16'h0);
                    return;
                end
                if (k == reset_at) begin
                    next_cycle();
                    data_m_access = 1'b1;
                    #2 check_outs({tag, ".in_reset"}, '0, 0, 0, 0, 1, 16'h0000);
                    next_cycle();
                    reset = 1'b0;
                    data_m_access = 1'b0;
                    #2 check_outs({tag, ".post_reset"}, '0, 0, 0, 0, 1, 16'h0000);
                    return;
                end
            end
        end

        next_cycle();
        dev_ack = '0;
        dev_sel = N'($urandom);
        #2 check_outs({tag, ".ack"}, '0, 1, mapped && timed, 0, 1,
                      mapped ? (timed ? 16'hFFFF : exp_data) : 16'hFFFF);

        for (int h = 0; h < hold; h++) begin
            next_cycle();
            dev_sel = N'($urandom | 1);
            default_io_access = 1'($urandom);
            #2 check_outs($sformatf("%s.hold%0d", tag, h), '0, 0, 0, 0, 0, 16'h0);
        end
        next_cycle();
        data_m_access = 1'b0;
        #2 check_outs({tag, ".release"}, '0, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        reset             = 1'b1;
        data_m_access     = 1'b0;
        data_m_wr_en      = 1'b0;
        default_io_access = 1'b0;
        dev_sel           = '0;
        dev_ack           = '0;
        dev_data          = '0;
        repeat (3) next_cycle();
        #2 check_outs("reset", '0, 0, 0, 0, 1, 16'h0000);
        next_cycle();
        reset = 1'b0;

        run_txn("uart_read", N'(1) << UART, 0, 0, 3, 0, 0, 0, 1, 16'h0055);
        run_txn("unmapped", N'(1) << UART, 1, 0, 1, 0, 0, 0, 0, 16'h0);
        run_txn("empty_sel", '0, 0, 0, 1, 0, 0, 1, 0, 16'h0);
        run_txn("vga_dead", N'(1) << VGA_REG, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        run_txn("ack_at_expiry", N'(1) << SPI, 0, 0, T, 0, 0, 0, 1, 16'h1234);
        run_txn("ack_first", N'(1) << SPARE, 0, 0, 1, 0, 0, 0, 1, 16'hA5C3);
        run_txn("pic_timer", (N'(1) << PIC) | (N'(1) << TIMER), 0, 0, 2, 0, 0, 0, 1, 16'h0F0F);
        run_txn("abort", N'(1) << UART, 0, 0, 0, 2, 0, 0, 0, 16'h0);
        run_txn("reset_wait", N'(1) << SPI, 0, 0, 0, 0, 3, 0, 0, 16'h0);
        run_txn("ppi_write", N'(1) << PPI, 0, 1, 2, 0, 0, 0, 1, 16'hBEEF);
        run_txn("held", N'(1) << LEDS, 0, 0, 2, 0, 0, 4, 1, 16'h7777);
        run_txn("default_write", '0, 1, 1, 1, 0, 0, 0, 0, 16'h0);

        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] sel;
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)      sel = '0;
            else if (r < 7) sel = N'(1) << $urandom_range(0, N - 1);
            else            sel = N'($urandom);
            run_txn($sformatf("rnd%0d", t), sel, ($urandom_range(0, 4) == 0), 1'($urandom),
                    $urandom_range(0, T + 1),
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, T) : 0,
                    0, $urandom_range(0, 4), 0, 16'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
